// File: rtl/led_seq_ctrl_if.sv
// led_seq_ctrl_if: switch/pause inputs and LED/status outputs of the LED sequencer.
// Ports: sw[3:0], pause -> DUT; led[3:0], tick, manual, phase[1:0] <- DUT.
interface led_seq_ctrl_if;
  logic [3:0] sw;
  logic       pause;
  logic [3:0] led;
  logic       tick;
  logic       manual;
  logic [1:0] phase;

  modport master (
    output sw,
    output pause,
    input  led,
    input  tick,
    input  manual,
    input  phase
  );

  modport slave (
    input  sw,
    input  pause,
    output led,
    output tick,
    output manual,
    output phase
  );
endinterface

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: single-clock LED fill/drain sequencer with debounced manual override.
// Ports: clk, rst (async high), bus (sw, pause in; led, tick, manual, phase out).
module led_seq_ctrl #(
  parameter int DIV       = 10,
  parameter int DB_CYCLES = 4
) (
  input logic           clk,
  input logic           rst,
  led_seq_ctrl_if.slave bus
);

  localparam int CW = $clog2(DIV + 1);
  localparam int DW = $clog2(DB_CYCLES + 1);

  localparam logic [CW-1:0] CNT_MAX = CW'(DIV);
  localparam logic [DW-1:0] DB_MAX  = DW'(DB_CYCLES);

  localparam logic [1:0] ST_BLANK  = 2'd0;
  localparam logic [1:0] ST_FILL   = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_MANUAL = 2'd3;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  logic [3:0]    s1_q, s1_d;
  logic [3:0]    s2_q, s2_d;
  logic [3:0]    cand_q, cand_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [3:0]    db_q, db_d;

  logic [1:0]    st_q, st_d;
  logic [3:0]    p_q, p_d;
  logic [3:0]    led_q, led_d;
  logic          man_q, man_d;

  logic [3:0]    p_nx;

  function automatic logic [3:0] pat(input logic [3:0] idx);
    logic [3:0] v;
    unique case (idx)
      4'd0:    v = 4'b0000;
      4'd1:    v = 4'b1000;
      4'd2:    v = 4'b1100;
      4'd3:    v = 4'b1110;
      4'd4:    v = 4'b1111;
      4'd5:    v = 4'b1110;
      4'd6:    v = 4'b1100;
      4'd7:    v = 4'b1000;
      default: v = 4'b0000;
    endcase
    return v;
  endfunction

  function automatic logic [1:0] ph_of(input logic [3:0] idx);
    logic [1:0] v;
    if (idx == 4'd0)
      v = ST_BLANK;
    else if (idx <= 4'd4)
      v = ST_FILL;
    else
      v = ST_DRAIN;
    return v;
  endfunction

  // Prescaler: tick is registered from the next count so it is
  // high exactly while the counter holds DIV.
  always_comb begin
    cnt_d  = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
    tick_d = (cnt_d == CNT_MAX);
  end

  // Two-flop synchronizer feeding a stability-window debouncer.
  always_comb begin
    s1_d   = bus.sw;
    s2_d   = s1_q;
    cand_d = cand_q;
    dcnt_d = dcnt_q;
    db_d   = db_q;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      dcnt_d = '0;
    end else if (dcnt_q < DB_MAX) begin
      dcnt_d = dcnt_q + DW'(1);
    end else begin
      db_d = cand_q;
    end
  end

  assign p_nx = (p_q == 4'd8) ? 4'd0 : p_q + 4'd1;

  // Sequencer: manual override first, then manual exit, then pause,
  // then the auto table. Uses pre-edge db_q on a coincident edge.
  always_comb begin
    st_d  = st_q;
    p_d   = p_q;
    led_d = led_q;
    if (tick_q) begin
      if (db_q != 4'b0000) begin
        st_d  = ST_MANUAL;
        led_d = db_q;
      end else if (st_q == ST_MANUAL) begin
        st_d  = ST_BLANK;
        p_d   = 4'd0;
        led_d = 4'b0000;
      end else if (bus.pause) begin
        st_d  = st_q;
      end else begin
        p_d   = p_nx;
        led_d = pat(p_nx);
        st_d  = ph_of(p_nx);
      end
    end
    man_d = (st_d == ST_MANUAL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      s1_q   <= 4'b0000;
      s2_q   <= 4'b0000;
      cand_q <= 4'b0000;
      dcnt_q <= '0;
      db_q   <= 4'b0000;
      st_q   <= ST_BLANK;
      p_q    <= 4'd0;
      led_q  <= 4'b0000;
      man_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      cand_q <= cand_d;
      dcnt_q <= dcnt_d;
      db_q   <= db_d;
      st_q   <= st_d;
      p_q    <= p_d;
      led_q  <= led_d;
      man_q  <= man_d;
    end
  end

  assign bus.led    = led_q;
  assign bus.tick   = tick_q;
  assign bus.manual = man_q;
  assign bus.phase  = st_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: directed checks of the LED sequencer with DIV=2, DB_CYCLES=2.
// Observes {manual, phase, led} once per tick, after the updating edge.
module tb_led_seq_ctrl;

  logic clk;
  logic rst;

  led_seq_ctrl_if bus ();

  led_seq_ctrl #(
    .DIV       (2),
    .DB_CYCLES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp;
  int n_err;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] obs();
    return {1'b0, bus.manual, bus.phase, bus.led};
  endfunction

  function automatic logic [7:0] ev(input logic m, input logic [1:0] ph, input logic [3:0] l);
    return {1'b0, m, ph, l};
  endfunction

  // Called at a negedge; returns at the negedge after the tick edge.
  task automatic wait_tick(output int n);
    n = 0;
    while (!bus.tick && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.tick) chk("tick_timeout", 8'd0, 8'd1);
    @(negedge clk);
  endtask

  task automatic step(input string tag, input logic [7:0] exp);
    int n;
    wait_tick(n);
    chk(tag, obs(), exp);
    chk({tag, "_tw"}, {7'd0, bus.tick}, 8'd0);
  endtask

  logic [3:0] t1_led [10] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b1110,
                              4'b1100, 4'b1000, 4'b0000, 4'b0000, 4'b1000};
  logic [1:0] t1_ph  [10] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2,
                              2'd2, 2'd2, 2'd2, 2'd0, 2'd1};

  initial begin
    int n;
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b0;
    bus.sw    = 4'b0000;
    bus.pause = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_out", obs(), ev(1'b0, 2'd0, 4'b0000));
    chk("rst_tick", {7'd0, bus.tick}, 8'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold", obs(), ev(1'b0, 2'd0, 4'b0000));
    rst = 1'b0;

    // auto fill/drain sequence and tick spacing
    for (int i = 0; i < 10; i++) begin
      wait_tick(n);
      chk($sformatf("t1_gap%0d", i), 8'(n), 8'd2);
      chk($sformatf("t1_seq%0d", i), obs(), ev(1'b0, t1_ph[i], t1_led[i]));
    end

    // short glitch is filtered
    bus.sw = 4'b0101;
    @(negedge clk);
    @(negedge clk);
    bus.sw = 4'b0000;
    step("gl_p2", ev(1'b0, 2'd1, 4'b1100));
    step("gl_p3", ev(1'b0, 2'd1, 4'b1110));
    step("gl_p4", ev(1'b0, 2'd1, 4'b1111));

    // held switch enters manual; debounce lands on a tick edge
    bus.sw = 4'b0101;
    step("mi_p5", ev(1'b0, 2'd2, 4'b1110));
    step("mi_edge", ev(1'b0, 2'd2, 4'b1100));
    step("mi_man", ev(1'b1, 2'd3, 4'b0101));

    // manual value changes with no intermediate value
    bus.sw = 4'b0001;
    step("mc_a0", ev(1'b1, 2'd3, 4'b0101));
    step("mc_a1", ev(1'b1, 2'd3, 4'b0101));
    step("mc_a2", ev(1'b1, 2'd3, 4'b0001));
    bus.sw = 4'b1000;
    step("mc_b0", ev(1'b1, 2'd3, 4'b0001));
    step("mc_b1", ev(1'b1, 2'd3, 4'b0001));
    step("mc_b2", ev(1'b1, 2'd3, 4'b1000));

    // manual exit restarts from blank
    bus.sw = 4'b0000;
    step("mx_0", ev(1'b1, 2'd3, 4'b1000));
    step("mx_1", ev(1'b1, 2'd3, 4'b1000));
    step("mx_blank", ev(1'b0, 2'd0, 4'b0000));
    step("mx_p1", ev(1'b0, 2'd1, 4'b1000));

    // pause holds the pattern, manual still overrides it
    step("pa_p2", ev(1'b0, 2'd1, 4'b1100));
    step("pa_p3", ev(1'b0, 2'd1, 4'b1110));
    bus.pause = 1'b1;
    for (int i = 0; i < 5; i++)
      step($sformatf("pa_hold%0d", i), ev(1'b0, 2'd1, 4'b1110));
    bus.pause = 1'b0;
    step("pa_p4", ev(1'b0, 2'd1, 4'b1111));
    bus.pause = 1'b1;
    bus.sw    = 4'b0011;
    step("pm_0", ev(1'b0, 2'd1, 4'b1111));
    step("pm_1", ev(1'b0, 2'd1, 4'b1111));
    step("pm_man", ev(1'b1, 2'd3, 4'b0011));
    bus.pause = 1'b0;
    bus.sw    = 4'b0000;
    step("pm_x0", ev(1'b1, 2'd3, 4'b0011));
    step("pm_x1", ev(1'b1, 2'd3, 4'b0011));
    step("pm_blank", ev(1'b0, 2'd0, 4'b0000));

    // run into drain, then async reset between edges
    step("dr_p1", ev(1'b0, 2'd1, 4'b1000));
    step("dr_p2", ev(1'b0, 2'd1, 4'b1100));
    step("dr_p3", ev(1'b0, 2'd1, 4'b1110));
    step("dr_p4", ev(1'b0, 2'd1, 4'b1111));
    step("dr_p5", ev(1'b0, 2'd2, 4'b1110));
    step("dr_p6", ev(1'b0, 2'd2, 4'b1100));
    #2 rst = 1'b1;
    #1;
    chk("ar_out", obs(), ev(1'b0, 2'd0, 4'b0000));
    chk("ar_tick", {7'd0, bus.tick}, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_tick(n);
    chk("ar_gap", 8'(n), 8'd2);
    chk("ar_first", obs(), ev(1'b0, 2'd1, 4'b1000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
